// File: rtl/mem_stage_pkg.sv
// Shared types and lane constants for the RV32I memory-access stage.
// Used by mem_stage (top) and mem_lsu_align (store/load lane logic).
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Size encoding 3 has no meaning of its own and is handled as a word access.
  function automatic mem_size_e eff_size(input logic [1:0] size);
    return (size == 2'd3) ? MEM_WORD : mem_size_e'(size);
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: store data replication / byte enables and
// load byte-lane extraction with sign or zero extension.
module mem_lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_signed,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_value
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    st_wdata = st_data;
    st_be    = BE_WORD;
    case (eff_size(st_size))
      MEM_BYTE: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = BE_BYTE << st_off;
      end
      MEM_HALF: begin
        st_wdata = {2{st_data[15:0]}};
        st_be    = BE_HALF << {st_off[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Halfword extraction ignores off[0], so a misaligned half reads its aligned pair.
  always_comb begin
    byte_sh  = ld_rdata >> {ld_off, 3'b000};
    half_sh  = ld_rdata >> {ld_off[1], 4'b0000};
    ld_value = ld_rdata;
    case (eff_size(ld_size))
      MEM_BYTE: ld_value = {{24{ld_signed & byte_sh[7]}}, byte_sh[7:0]};
      MEM_HALF: ld_value = {{16{ld_signed & half_sh[15]}}, half_sh[15:0]};
      default:  ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results or runs one load/store on a
// single-outstanding req/ack bus. Optional MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [4:0]  ex_rd_index_r,
  input  logic [31:0] ex_alu_res_r,
  input  logic [31:0] ex_mem_data_r,
  input  logic        ex_mem_rd_r,
  input  logic        ex_mem_wr_r,
  input  logic        ex_mem_signed_r,
  input  logic [1:0]  ex_mem_size_r,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [4:0]  mem_rd_index_r,
  output logic [31:0] mem_rd_value_r,
  output logic        mem_bus_err_r,
  output mem_state_e  mem_state_dbg,
  output logic        mem_stall_w
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        mem_misalign_r,
  output logic [31:0] mem_fault_addr_r
`endif
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  mem_state_e        state, state_next;
  logic [CNT_W-1:0]  wd_cnt;
  logic [1:0]        lat_off;
  logic [1:0]        lat_size;
  logic              lat_signed;
  logic [4:0]        lat_rd;
  logic              mem_op;
  logic              misalign;
  logic              expire;
  logic [31:0]       st_wdata;
  logic [3:0]        st_be;
  logic [31:0]       ld_value;

  assign mem_op = ex_mem_rd_r | ex_mem_wr_r;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = mem_op &&
                    (((eff_size(ex_mem_size_r) == MEM_HALF) && ex_alu_res_r[0]) ||
                     ((eff_size(ex_mem_size_r) == MEM_WORD) && (ex_alu_res_r[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Expiry fires in the REQ cycle that would be the ACK_TIMEOUT-th without an ack.
  assign expire = (ACK_TIMEOUT > 0) && (state == REQ) && !dmem_ack_i &&
                  (wd_cnt == CNT_W'(ACK_TIMEOUT - 1));

  assign mem_state_dbg = state;

  mem_lsu_align u_align (
    .st_size   (ex_mem_size_r),
    .st_off    (ex_alu_res_r[1:0]),
    .st_data   (ex_mem_data_r),
    .st_wdata  (st_wdata),
    .st_be     (st_be),
    .ld_size   (lat_size),
    .ld_off    (lat_off),
    .ld_signed (lat_signed),
    .ld_rdata  (dmem_rdata_i),
    .ld_value  (ld_value)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_next;
  end

  // Handshake: a request is offered while dmem_req_o = 1 with every bus field
  // held stable; it completes in the cycle dmem_ack_i = 1 (rdata valid then).
  always_comb begin
    state_next  = state;
    mem_stall_w = 1'b0;
    case (state)
      IDLE: begin
        mem_stall_w = mem_op & ~misalign;
        if (mem_op && !misalign) state_next = REQ;
      end
      REQ: begin
        mem_stall_w = ~dmem_ack_i & ~expire;
        if (dmem_ack_i || expire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      dmem_req_o       <= 1'b0;
      dmem_we_o        <= 1'b0;
      dmem_addr_o      <= '0;
      dmem_be_o        <= '0;
      dmem_wdata_o     <= '0;
      mem_rd_index_r   <= '0;
      mem_rd_value_r   <= '0;
      mem_bus_err_r    <= 1'b0;
      wd_cnt           <= '0;
      lat_off          <= '0;
      lat_size         <= '0;
      lat_signed       <= 1'b0;
      lat_rd           <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign_r   <= 1'b0;
      mem_fault_addr_r <= '0;
`endif
    end else begin
      mem_bus_err_r  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (mem_op && !misalign) begin
            dmem_req_o     <= 1'b1;
            dmem_we_o      <= ex_mem_wr_r;
            dmem_addr_o    <= {ex_alu_res_r[31:2], 2'b00};
            dmem_be_o      <= st_be;
            dmem_wdata_o   <= st_wdata;
            lat_off        <= ex_alu_res_r[1:0];
            lat_size       <= ex_mem_size_r;
            lat_signed     <= ex_mem_signed_r;
            lat_rd         <= ex_rd_index_r;
            mem_rd_index_r <= '0;
          end else if (misalign) begin
            mem_rd_index_r   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            mem_misalign_r   <= 1'b1;
            mem_fault_addr_r <= ex_alu_res_r;
`endif
          end else begin
            mem_rd_index_r <= ex_rd_index_r;
            mem_rd_value_r <= ex_alu_res_r;
          end
        end
        REQ: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            wd_cnt     <= '0;
            if (dmem_we_o) begin
              mem_rd_index_r <= '0;
            end else begin
              mem_rd_index_r <= lat_rd;
              mem_rd_value_r <= ld_value;
            end
          end else if (expire) begin
            dmem_req_o     <= 1'b0;
            wd_cnt         <= '0;
            mem_bus_err_r  <= 1'b1;
            mem_rd_index_r <= '0;
          end else begin
            wd_cnt         <= wd_cnt + CNT_W'(1);
            mem_rd_index_r <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random ALU/load/store traffic against a
// behavioural model, plus directed reset, timeout and lane cases.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [4:0]  ex_rd_index_r = '0;
  logic [31:0] ex_alu_res_r = '0;
  logic [31:0] ex_mem_data_r = '0;
  logic        ex_mem_rd_r = 1'b0;
  logic        ex_mem_wr_r = 1'b0;
  logic        ex_mem_signed_r = 1'b0;
  logic [1:0]  ex_mem_size_r = '0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic [4:0]  mem_rd_index_r;
  logic [31:0] mem_rd_value_r;
  logic        mem_bus_err_r;
  mem_state_e  mem_state_dbg;
  logic        mem_stall_w;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_misalign_r;
  logic [31:0] mem_fault_addr_r;
`endif

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int exp_err = 0;
  int last_req_cycles = 0;

  logic [36:0] exp_q[$];
  bus_t        bus_q[$];
  logic [31:0] fault_q[$];

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .ex_rd_index_r   (ex_rd_index_r),
    .ex_alu_res_r    (ex_alu_res_r),
    .ex_mem_data_r   (ex_mem_data_r),
    .ex_mem_rd_r     (ex_mem_rd_r),
    .ex_mem_wr_r     (ex_mem_wr_r),
    .ex_mem_signed_r (ex_mem_signed_r),
    .ex_mem_size_r   (ex_mem_size_r),
    .dmem_req_o      (dmem_req_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_addr_o     (dmem_addr_o),
    .dmem_be_o       (dmem_be_o),
    .dmem_wdata_o    (dmem_wdata_o),
    .dmem_ack_i      (dmem_ack_i),
    .dmem_rdata_i    (dmem_rdata_i),
    .mem_rd_index_r  (mem_rd_index_r),
    .mem_rd_value_r  (mem_rd_value_r),
    .mem_bus_err_r   (mem_bus_err_r),
    .mem_state_dbg   (mem_state_dbg),
    .mem_stall_w     (mem_stall_w)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .mem_misalign_r  (mem_misalign_r),
    .mem_fault_addr_r(mem_fault_addr_r)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input int off,
                                             input int sz, input bit sgn);
    longint v;
    if (sz == 0) begin
      v = (rdata >> (8 * off)) % 256;
      if (sgn && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = (rdata >> (8 * ((off / 2) * 2))) % 65536;
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      v = rdata;
    end
    return v[31:0];
  endfunction

  task automatic issue(input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] data,
                       input bit ld, input bit st, input bit sgn, input logic [1:0] size,
                       input int lat, input logic [31:0] rdata);
    int sz, off, exp_stall, stalls;
    bit is_mem, mis;
    bus_t b;
    logic [31:0] d8, d16;
    is_mem = ld || st;
    sz  = (size == 2'd3) ? 2 : int'(size);
    off = int'(addr[1:0]);
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = is_mem && ((sz == 1 && off % 2 == 1) || (sz == 2 && off != 0));
`endif
    if (!is_mem) begin
      exp_stall = 0;
      if (rd != 0) exp_q.push_back({rd, addr});
    end else if (mis) begin
      exp_stall = 0;
      fault_q.push_back(addr);
    end else begin
      d8  = {24'h0, data[7:0]};
      d16 = {16'h0, data[15:0]};
      b.addr  = addr - 32'(off);
      b.we    = st;
      b.be    = (sz == 0) ? 4'(1 << off) : (sz == 1) ? 4'(3 << ((off / 2) * 2)) : 4'hF;
      b.wdata = (sz == 0) ? d8 * 32'h0101_0101 : (sz == 1) ? d16 * 32'h0001_0001 : data;
      b.lat   = lat;
      b.rdata = rdata;
      bus_q.push_back(b);
      if (lat >= TO) begin
        exp_stall = TO;
        exp_err++;
      end else begin
        exp_stall = 1 + lat;
        if (!st && rd != 0) exp_q.push_back({rd, model_load(rdata, off, sz, sgn)});
      end
    end
    ex_rd_index_r   = rd;
    ex_alu_res_r    = addr;
    ex_mem_data_r   = data;
    ex_mem_rd_r     = ld;
    ex_mem_wr_r     = st;
    ex_mem_signed_r = sgn;
    ex_mem_size_r   = size;
    stalls = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (!mem_stall_w) break;
      stalls++;
      @(posedge clk); #1;
    end
    check("stall_cycles", 64'(stalls), 64'(exp_stall));
    @(posedge clk); #1;
    ex_rd_index_r = '0;
    ex_mem_rd_r   = 1'b0;
    ex_mem_wr_r   = 1'b0;
  endtask

  // bus slave and request checker
  bus_t        cur;
  logic [68:0] held;
  bit          active = 1'b0;
  int          wait_n = 0;
  int          req_cycles = 0;

  always @(posedge clk) begin
    #1;
    if (!dmem_req_o) begin
      if (active) last_req_cycles = req_cycles;
      active     = 1'b0;
      dmem_ack_i = 1'b0;
    end else begin
      if (!active) begin
        active     = 1'b1;
        wait_n     = 0;
        req_cycles = 0;
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected_req addr=%0h", dmem_addr_o);
          cur.lat = 0;
          cur.rdata = '0;
        end else begin
          cur = bus_q.pop_front();
          check("bus_addr", 64'(dmem_addr_o), 64'(cur.addr));
          check("bus_we", 64'(dmem_we_o), 64'(cur.we));
          if (cur.we) begin
            check("bus_be", 64'(dmem_be_o), 64'(cur.be));
            check("bus_wdata", 64'(dmem_wdata_o), 64'(cur.wdata));
          end
        end
        held = {dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o};
      end else begin
        check("bus_stable", 64'({dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o}), 64'(held));
      end
      req_cycles++;
      if (wait_n == cur.lat) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = cur.rdata;
      end else begin
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = $urandom;
        wait_n++;
      end
    end
  end

  // writeback monitor
  always @(negedge clk) begin
    if (reset_i === 1'b1 && mem_rd_index_r != 5'd0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected actual=%0h expected=none", {mem_rd_index_r, mem_rd_value_r});
      end else begin
        check("wb", 64'({mem_rd_index_r, mem_rd_value_r}), 64'(exp_q.pop_front()));
      end
    end
    if (reset_i === 1'b1 && mem_bus_err_r) err_seen++;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always @(negedge clk) begin
    if (reset_i === 1'b1 && mem_misalign_r) begin
      if (fault_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL misalign_unexpected actual=%0h expected=none", mem_fault_addr_r);
      end else begin
        check("fault_addr", 64'(mem_fault_addr_r), 64'(fault_q.pop_front()));
      end
    end
  end
`endif

  initial begin
    logic [31:0] a;
    #1 reset_i = 1'b0;
    #1;
    check("rst_req", 64'(dmem_req_o), 64'd0);
    check("rst_index", 64'(mem_rd_index_r), 64'd0);
    check("rst_value", 64'(mem_rd_value_r), 64'd0);
    check("rst_err", 64'(mem_bus_err_r), 64'd0);
    check("rst_stall", 64'(mem_stall_w), 64'd0);
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk); #1;

    // ALU pass-through
    issue(5'd5, 32'h1234, 32'h0, 0, 0, 0, 2'd2, 0, 32'h0);
    // signed / unsigned byte loads
    issue(5'd7, 32'h103, 32'h0, 1, 0, 1, 2'd0, 2, 32'h80FF_FF00);
    issue(5'd8, 32'h103, 32'h0, 1, 0, 0, 2'd0, 2, 32'h80FF_FF00);
    // half store, immediate ack
    issue(5'd9, 32'h22, 32'hAAAA_BEEF, 0, 1, 0, 2'd1, 0, 32'h0);

    // watchdog
    issue(5'd6, 32'h200, 32'h0, 1, 0, 0, 2'd2, 1000, 32'h1111_2222);
    repeat (2) @(posedge clk);
    #2;
    check("timeout_req_cycles", 64'(last_req_cycles), 64'(TO));
    check("timeout_err_pulses", 64'(err_seen), 64'd1);
    @(posedge clk); #1;
    issue(5'd5, 32'h5555, 32'h0, 0, 0, 0, 2'd0, 0, 32'h0);

    // reset in the middle of an access
    a = 32'h80;
    bus_q.push_back('{addr: a, we: 1'b0, be: 4'hF, wdata: 32'h0, lat: 1000, rdata: 32'h0});
    ex_rd_index_r = 5'd3; ex_alu_res_r = a; ex_mem_rd_r = 1'b1; ex_mem_size_r = 2'd2;
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset_i = 1'b0;
    ex_rd_index_r = '0; ex_mem_rd_r = 1'b0;
    #1;
    check("midrst_req", 64'(dmem_req_o), 64'd0);
    check("midrst_bus", 64'({dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o}), 64'd0);
    check("midrst_wb", 64'({mem_rd_index_r, mem_rd_value_r}), 64'd0);
    check("midrst_stall", 64'(mem_stall_w), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk); #1;
    issue(5'd9, 32'h40, 32'h0, 1, 0, 0, 2'd2, $urandom_range(0, 3), 32'hDEAD_BEEF);

`ifdef MEM_MISALIGN_TRAP_EN
    issue(5'd4, 32'h41, 32'h0, 1, 0, 0, 2'd2, 0, 32'h0);
`endif

    // random traffic
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      issue(5'($urandom_range(0, 31)), $urandom, $urandom,
            kind == 1 || kind == 3, kind >= 2, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom);
    end

    repeat (4) @(posedge clk);
    #2;
    check("wb_queue_drained", 64'(exp_q.size()), 64'd0);
    check("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    check("fault_queue_drained", 64'(fault_q.size()), 64'd0);
    check("bus_err_total", 64'(err_seen), 64'(exp_err));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
